// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: instruction kinds, opcodes, funct codes and
// field-packing helpers used by both the instruction encoder and the decoder.
package mips_pkg;

   typedef enum logic [3:0] {
      K_ADD   = 4'd0,
      K_SUB   = 4'd1,
      K_AND   = 4'd2,
      K_OR    = 4'd3,
      K_SLT   = 4'd4,
      K_SLL   = 4'd5,
      K_JR    = 4'd6,
      K_LW    = 4'd7,
      K_SW    = 4'd8,
      K_BEQ   = 4'd9,
      K_BNE   = 4'd10,
      K_ADDI  = 4'd11,
      K_ADDIU = 4'd12,
      K_J     = 4'd13,
      K_JAL   = 4'd14
   } instr_kind_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } enc_state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_JR  = 6'b001000;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
      return {OP_RTYPE, rs, rt, rd, shamt, funct};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
      return {op, target};
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic instruction kind plus fields -> 32-bit MIPS word.
// Fields a format does not use are forced to zero so the word is canonical.
module instr_pack
   import mips_pkg::*;
(
   input  logic [3:0]  kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        legal
);

   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (kind)
         K_ADD:   word = r_word(rs, rt, rd, 5'd0, FN_ADD);
         K_SUB:   word = r_word(rs, rt, rd, 5'd0, FN_SUB);
         K_AND:   word = r_word(rs, rt, rd, 5'd0, FN_AND);
         K_OR:    word = r_word(rs, rt, rd, 5'd0, FN_OR);
         K_SLT:   word = r_word(rs, rt, rd, 5'd0, FN_SLT);
         K_SLL:   word = r_word(5'd0, rt, rd, shamt, FN_SLL);
         K_JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
         K_LW:    word = i_word(OP_LW, rs, rt, imm);
         K_SW:    word = i_word(OP_SW, rs, rt, imm);
         K_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
         K_BNE:   word = i_word(OP_BNE, rs, rt, imm);
         K_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
         K_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm);
         K_J:     word = j_word(OP_J, target);
         K_JAL:   word = j_word(OP_JAL, target);
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-memory loader: accepts symbolic requests, packs them into MIPS
// words and writes them to consecutive word addresses from a programmed base.
module instr_encoder
   import mips_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [31:0]                  base_addr,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [3:0]                   req_kind,
   input  logic [4:0]                   req_rs,
   input  logic [4:0]                   req_rt,
   input  logic [4:0]                   req_rd,
   input  logic [4:0]                   req_shamt,
   input  logic [15:0]                  req_imm,
   input  logic [25:0]                  req_target,
   input  logic                         req_last,
   output logic                         imem_we,
   output logic [31:0]                  imem_addr,
   output logic [31:0]                  imem_wdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         busy,
   output logic                         done,
   output logic                         error,
   output logic [1:0]                   state_dbg
);

   localparam int CW = $clog2(DEPTH+1);

   // Handshake: a request transfers on any rising edge where req_valid && req_ready;
   // req_ready is high exactly while in LOAD and never depends on req_valid.
   enc_state_t      state_q, state_d;
   logic [31:0]     ptr_q, ptr_d;
   logic [CW-1:0]   count_q, count_d, count_inc;
   logic            err_q, err_d;
   logic            we_q, we_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     pack_word;
   logic            pack_legal;

   instr_pack u_pack (
      .kind   (req_kind),
      .rs     (req_rs),
      .rt     (req_rt),
      .rd     (req_rd),
      .shamt  (req_shamt),
      .imm    (req_imm),
      .target (req_target),
      .word   (pack_word),
      .legal  (pack_legal)
   );

   assign count_inc = count_q + CW'(1);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      err_d   = err_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_LOAD;
               ptr_d   = {base_addr[31:2], 2'b00};
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (req_valid) begin
               if (pack_legal) begin
                  we_d    = 1'b1;
                  addr_d  = ptr_q;
                  wdata_d = pack_word;
                  ptr_d   = ptr_q + 32'd4;
                  count_d = count_inc;
               end else begin
                  err_d = 1'b1;
               end
               // A full session without req_last is an overflow.
               if (req_last) begin
                  state_d = S_FLUSH;
               end else if (pack_legal && count_inc == CW'(DEPTH)) begin
                  state_d = S_FLUSH;
                  err_d   = 1'b1;
               end
            end
         end
         S_FLUSH: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign req_ready  = (state_q == S_LOAD);
   assign busy       = (state_q == S_LOAD) || (state_q == S_FLUSH);
   assign done       = (state_q == S_DONE);
   assign error      = err_q;
   assign count      = count_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH = 4) with a word-level expected-write model.
module tb_instr_encoder;
   import mips_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk, rst_n, start, req_valid, req_ready, req_last;
   logic [31:0]   base_addr;
   logic [3:0]    req_kind;
   logic [4:0]    req_rs, req_rt, req_rd, req_shamt;
   logic [15:0]   req_imm;
   logic [25:0]   req_target;
   logic          imem_we, busy, done, error;
   logic [31:0]   imem_addr, imem_wdata;
   logic [CW-1:0] count;
   logic [1:0]    state_dbg;

   int tests = 0;
   int fails = 0;

   logic [63:0]   exp_q[$];
   bit            m_active;
   int            m_count;
   bit            m_err;
   logic [31:0]   m_ptr;

   instr_encoder #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
      .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .count(count), .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Word assembled from opcode/funct lookup and positional weights of each field.
   function automatic logic [31:0] model_word(input logic [3:0] k, input int unsigned rs,
                                              input int unsigned rt, input int unsigned rd,
                                              input int unsigned sh, input int unsigned imm,
                                              input int unsigned tgt, output bit legal);
      int unsigned op, fn, w;
      bit r_fmt, j_fmt, k_rs, k_rt, k_rd, k_sh;
      legal = 1'b1; op = 0; fn = 0; r_fmt = 1'b0; j_fmt = 1'b0;
      k_rs = 1'b1; k_rt = 1'b1; k_rd = 1'b1; k_sh = 1'b0;
      case (k)
         K_ADD:   begin r_fmt = 1'b1; fn = 32; end
         K_SUB:   begin r_fmt = 1'b1; fn = 34; end
         K_AND:   begin r_fmt = 1'b1; fn = 36; end
         K_OR:    begin r_fmt = 1'b1; fn = 37; end
         K_SLT:   begin r_fmt = 1'b1; fn = 42; end
         K_SLL:   begin r_fmt = 1'b1; fn = 0; k_rs = 1'b0; k_sh = 1'b1; end
         K_JR:    begin r_fmt = 1'b1; fn = 8; k_rt = 1'b0; k_rd = 1'b0; end
         K_LW:    op = 35;
         K_SW:    op = 43;
         K_BEQ:   op = 4;
         K_BNE:   op = 5;
         K_ADDI:  op = 8;
         K_ADDIU: op = 9;
         K_J:     begin op = 2; j_fmt = 1'b1; end
         K_JAL:   begin op = 3; j_fmt = 1'b1; end
         default: legal = 1'b0;
      endcase
      if (!legal)
         w = 0;
      else if (j_fmt)
         w = op * 67108864 + tgt;
      else if (r_fmt)
         w = (k_rs ? rs : 0) * 2097152 + (k_rt ? rt : 0) * 65536
           + (k_rd ? rd : 0) * 2048 + (k_sh ? sh : 0) * 64 + fn;
      else
         w = op * 67108864 + rs * 2097152 + rt * 65536 + imm;
      return w;
   endfunction

   // Every cycle: any DUT write must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n && imem_we) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL stray_write: got addr 0x%0h data 0x%0h, expected no write",
                     imem_addr, imem_wdata);
         end else begin
            chk("write", {imem_addr, imem_wdata}, exp_q.pop_front());
         end
      end
   end

   task automatic do_start(input logic [31:0] base);
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = base;
      @(posedge clk);
      m_active = 1'b1;
      m_count = 0;
      m_err = 1'b0;
      m_ptr = base & 32'hFFFF_FFFC;
      #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] k, input int unsigned rs, input int unsigned rt,
                       input int unsigned rd, input int unsigned sh, input int unsigned imm,
                       input int unsigned tgt, input bit last);
      bit acc, exp_acc, legal;
      logic [31:0] w;
      exp_acc = m_active;
      acc = 1'b0;
      req_valid = 1'b1; req_kind = k; req_rs = rs[4:0]; req_rt = rt[4:0]; req_rd = rd[4:0];
      req_shamt = sh[4:0]; req_imm = imm[15:0]; req_target = tgt[25:0]; req_last = last;
      for (int i = 0; i < 4 && !acc; i++) begin
         @(negedge clk);
         if (req_ready) begin
            @(posedge clk);
            acc = 1'b1;
         end
      end
      if (acc && m_active) begin
         w = model_word(k, rs, rt, rd, sh, imm, tgt, legal);
         if (!legal) begin
            m_err = 1'b1;
         end else begin
            exp_q.push_back({m_ptr, w});
            m_ptr = m_ptr + 32'd4;
            m_count++;
         end
         if (last) begin
            m_active = 1'b0;
         end else if (legal && m_count == DEPTH) begin
            m_active = 1'b0;
            m_err = 1'b1;
         end
      end
      #1;
      req_valid = 1'b0;
      req_last = 1'b0;
      chk("accept", {63'd0, acc}, {63'd0, exp_acc});
   endtask

   // exact: called right after the final accept, so FLUSH then DONE follow.
   task automatic end_session(input bit exact);
      if (exact) begin
         @(negedge clk);
         chk("flush_busy", {62'd0, busy, done}, {62'd0, 2'b10});
         @(negedge clk);
      end else begin
         for (int i = 0; i < 10 && !done; i++) @(negedge clk);
      end
      chk("done", {63'd0, done}, 64'd1);
      chk("busy_ready", {62'd0, busy, req_ready}, 64'd0);
      chk("count", 64'(count), 64'(m_count));
      chk("error", {63'd0, error}, {63'd0, m_err});
      chk("pending_writes", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk(name, {req_ready, imem_we, busy, done, error, state_dbg, 57'(count)}, 64'd0);
      chk({name, "_bus"}, {imem_addr, imem_wdata}, 64'd0);
   endtask

   bit lg;

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; req_valid = 1'b0; req_last = 1'b0;
      req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_shamt = '0;
      req_imm = '0; req_target = '0;
      m_active = 1'b0; m_count = 0; m_err = 1'b0; m_ptr = '0;
      #12;
      chk_reset_outputs("reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      // Literal pins on the model.
      chk("pin_add", 64'(model_word(K_ADD, 1, 2, 3, 0, 0, 0, lg)), 64'h00221820);
      chk("pin_lw", 64'(model_word(K_LW, 29, 8, 0, 0, 4, 0, lg)), 64'h8FA80004);
      chk("pin_sll", 64'(model_word(K_SLL, 7, 3, 2, 4, 0, 0, lg)), 64'h00031100);
      chk("pin_beq", 64'(model_word(K_BEQ, 1, 2, 0, 0, 16'hFFFF, 0, lg)), 64'h1022FFFF);
      chk("pin_j", 64'(model_word(K_J, 0, 0, 0, 0, 0, 26'h0100000, lg)), 64'h08100000);
      chk("pin_jal", 64'(model_word(K_JAL, 0, 0, 0, 0, 0, 26'h10, lg)), 64'h0C000010);
      chk("pin_illegal", {63'd0, lg}, 64'd1);
      void'(model_word(4'hF, 0, 0, 0, 0, 0, 0, lg));
      chk("pin_illegal_flag", {63'd0, lg}, 64'd0);

      // ADD then LW with last.
      do_start(32'h0000_0040);
      send(K_ADD, 1, 2, 3, 0, 0, 0, 1'b0);
      send(K_LW, 29, 8, 0, 0, 4, 0, 1'b1);
      end_session(1'b1);
      chk("basic_count_literal", 64'(count), 64'd2);

      // Four words ending exactly at DEPTH with last: no overflow.
      do_start(32'h0000_0100);
      send(K_SLL, 7, 3, 2, 4, 0, 0, 1'b0);
      send(K_BEQ, 1, 2, 9, 3, 16'hFFFF, 0, 1'b0);
      send(K_J, 0, 0, 0, 0, 0, 26'h0100000, 1'b0);
      send(K_JAL, 0, 0, 0, 0, 0, 26'h10, 1'b1);
      end_session(1'b1);

      // Illegal kind between two legal requests; ADD carries a nonzero shamt.
      do_start(32'h0000_0200);
      send(K_ADD, 4, 5, 6, 7, 0, 0, 1'b0);
      send(4'hF, 1, 1, 1, 1, 0, 0, 1'b0);
      send(K_SUB, 8, 9, 10, 11, 0, 0, 1'b1);
      end_session(1'b1);

      // Overflow: six requests without last.
      do_start(32'h0000_0300);
      send(K_AND, 1, 2, 3, 0, 0, 0, 1'b0);
      send(K_OR, 4, 5, 6, 1, 0, 0, 1'b0);
      send(K_SLT, 7, 8, 9, 2, 0, 0, 1'b0);
      send(K_JR, 31, 12, 13, 14, 0, 0, 1'b0);
      send(K_ADD, 1, 1, 1, 0, 0, 0, 1'b0);
      send(K_SUB, 2, 2, 2, 0, 0, 0, 1'b0);
      end_session(1'b0);
      chk("overflow_error_literal", {63'd0, error}, 64'd1);

      // Pointer wrap, low address bits dropped, I-type ignores rd/shamt.
      do_start(32'hFFFF_FFFE);
      send(K_SW, 3, 4, 31, 31, 16'h8000, 0, 1'b0);
      send(K_BNE, 5, 6, 1, 1, 16'h0010, 0, 1'b0);
      send(K_ADDI, 7, 8, 0, 0, 16'hFFFE, 0, 1'b0);
      send(K_ADDIU, 9, 10, 0, 0, 16'h1234, 0, 1'b1);
      end_session(1'b1);

      // Illegal request carrying last ends the session.
      do_start(32'h0000_0400);
      send(K_ADD, 1, 2, 3, 0, 0, 0, 1'b0);
      send(4'hF, 0, 0, 0, 0, 0, 0, 1'b1);
      end_session(1'b1);

      // start during LOAD is ignored.
      do_start(32'h0000_0440);
      send(K_OR, 1, 2, 3, 0, 0, 0, 1'b0);
      start = 1'b1;
      base_addr = 32'h0000_9000;
      @(posedge clk);
      #1;
      start = 1'b0;
      send(K_AND, 3, 2, 1, 0, 0, 0, 1'b1);
      end_session(1'b1);

      // Reset right after an accept drops the in-flight write.
      do_start(32'h0000_0500);
      send(K_ADD, 1, 2, 3, 0, 0, 0, 1'b0);
      rst_n = 1'b0;
      exp_q.delete();
      m_active = 1'b0;
      #1;
      chk_reset_outputs("reset_mid");
      @(negedge clk);
      chk_reset_outputs("reset_hold");
      rst_n = 1'b1;
      do_start(32'h0000_0600);
      send(K_LW, 29, 8, 0, 0, 4, 0, 1'b1);
      end_session(1'b1);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and instruction-memory loader: the writing side of the single-cycle core's instruction decode path. It accepts a stream of symbolic instruction requests over a valid/ready handshake, packs each into a 32-bit MIPS word (R/I/J format), and writes the words to consecutive instruction-memory addresses starting at a programmed base. It sits between the test/boot host and the instruction memory and is active only while the core is held idle.

## Interface
- DEPTH, 256: maximum number of words one load session may write.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; opens a load session (ignored unless IDLE or DONE).
- base_addr  in  32  byte address of first word, sampled on start; bits [1:0] forced to 0.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_kind  in  4  instr_kind_t: ADD, SUB, AND, OR, SLT, SLL, JR, LW, SW, BEQ, BNE, ADDI, ADDIU, J, JAL; other codes are illegal.
- req_rs, req_rt, req_rd, req_shamt  in  5 each  register/shift fields.
- req_imm  in  16  I-type immediate (raw two's-complement bits).
- req_target  in  26  J-type word target.
- req_last  in  1  marks final request of the session.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  32  byte address of write.
- imem_wdata  out  32  encoded instruction word.
- count  out  $clog2(DEPTH+1)  words written this session.
- busy  out  1  session in progress (LOAD or FLUSH).
- done  out  1  level; session finished.
- error  out  1  sticky; illegal kind or overflow seen this session.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE/DONE --start--> LOAD: addr pointer := base_addr & ~3, count := 0, error := 0, done := 0.
- LOAD: req_ready = 1. On accept: encode into output register, advance pointer. If req_last or count+1 == DEPTH, go to FLUSH.
- FLUSH: req_ready = 0; the final registered write retires this cycle; then go to DONE (done = 1).
- Encoding: R-type op = 000000, fields rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]. Funct values: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, SLL 000000, JR 001000.
- R-type field masking: SLL forces rs = 0; JR forces rt = rd = shamt = 0; other R kinds force shamt = 0.
- I-type: op[31:26], rs, rt, imm[15:0]. Opcodes: LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ADDIU 001001.
- J-type: op[31:26], target[25:0]. Opcodes: J 000010, JAL 000011.
- Illegal kind: the request is consumed, no write occurs, the pointer and count do not advance, and error is set. req_last on an illegal request still ends the session.
- Overflow: reaching DEPTH words without req_last ends the session and sets error.
- Address pointer wraps modulo 2^32 without error.
- start while LOAD/FLUSH: ignored.

## Timing
- Request accepted at edge N -> imem_we = 1 with that word and address during cycle N+1. Throughput is one word per cycle; there is no backpressure from memory.
- count increments at the same edge that registers imem_we.
- done rises the cycle after FLUSH, i.e. two cycles after the last accept.
- Reset values: req_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, count 0, busy 0, done 0, error 0, state IDLE.
- Reset mid-session: the write in flight is dropped and all outputs return to reset values immediately (async).

## Structure
- Shared package mips_pkg: instr_kind_t enum, OP_* opcode and FN_* funct localparams. The control unit's decoder consumes the same package, so encoder and decoder cannot diverge.
- Combinational sub-module instr_pack (kind + fields -> 32-bit word + legal flag). instr_encoder owns the FSM, pointer, counter and output register.

## Test plan
- base 0x0000_0040; ADD rs1 rt2 rd3, then LW rs29 rt8 imm4 with last -> writes 0x00221820 @0x40 and 0x8FA80004 @0x44; count = 2, done = 1, error = 0.
- SLL rd2 rt3 shamt4 (rs = 7 supplied) -> 0x00031100. BEQ rs1 rt2 imm 0xFFFF -> 0x1022FFFF.
- J target 0x0100000 -> 0x08100000. JAL target 0x10 -> 0x0C000010.
- Illegal kind between two legal requests -> the two legal words land at base and base+4, count = 2, error = 1.
- DEPTH = 4, six requests offered without last -> 4 writes, then req_ready drops, done = 1, error = 1.
- rst_n asserted on the cycle after an accept -> no imem_we that cycle; all outputs zero; the next start begins cleanly at the new base.
